// File: rtl/ch6_timer_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
//   TIMER_WIDTH : default counter width
//   state_t     : timer FSM state encoding
package ch6_timer_pkg;

  localparam int unsigned TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/down_count_stage.sv
// One bit of the synchronous down-counter chain.
//   clk, clear   : rising-edge clock, async active-low reset
//   load         : parallel-load strobe, load_bit is the value taken
//   dec          : decrement enable for the whole chain
//   borrow_in    : 1 when every lower bit is 0 (bit toggles on decrement)
//   q            : stored bit
//   borrow_out   : borrow passed to the next higher bit
module down_count_stage (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic load_bit,
  input  logic dec,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  // Borrow ripples up only through bits that are currently 0.
  assign borrow_out = borrow_in & ~q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_bit;
    end else if (dec && borrow_in) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/four_bit_sync_down_timer.sv
// Loadable synchronous down-counter/timer with one-shot or periodic expiry.
//   clk          : rising-edge clock
//   clear        : async active-low reset
//   count_enable : decrement qualifier
//   load         : synchronous load of load_value (highest priority after clear)
//   load_value   : start / reload value
//   auto_reload  : 1 reloads on expiry and keeps running, 0 stops in EXPIRED
//   Q            : current count
//   busy         : 1 while running
//   done         : one-cycle pulse after the terminal-count cycle
//   expired      : level, 1 in EXPIRED until the next load
//   tc           : combinational terminal count for cascading
import ch6_timer_pkg::*;

module four_bit_sync_down_timer #(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic             tc
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             done_next;
  logic             stage_load;
  logic [WIDTH-1:0] load_data;
  logic             dec_en;
  logic [WIDTH:0]   borrow;
  logic             q_zero;

  // Bit-stage chain; the borrow out of the top stage doubles as a Q==0 flag.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    down_count_stage u_stage (
      .clk        (clk),
      .clear      (clear),
      .load       (stage_load),
      .load_bit   (load_data[i]),
      .dec        (dec_en),
      .borrow_in  (borrow[i]),
      .q          (Q[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign q_zero = borrow[WIDTH];

  assign tc = (state == ST_RUN) && count_enable && (Q == WIDTH'(1));

  // State and registered flag update.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= ST_IDLE;
      reload_reg <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_next;
      reload_reg <= reload_next;
      done       <= done_next;
      busy       <= (state_next == ST_RUN);
      expired    <= (state_next == ST_EXPIRED);
    end
  end

  // Next-state, reload and counter-control decode: load beats counting.
  always_comb begin
    state_next  = state;
    reload_next = reload_reg;
    done_next   = 1'b0;
    stage_load  = 1'b0;
    load_data   = load_value;
    dec_en      = 1'b0;

    if (load) begin
      reload_next = load_value;
      stage_load  = 1'b1;
      state_next  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (count_enable) begin
            if (Q == WIDTH'(1)) begin
              done_next = 1'b1;
              if (auto_reload) begin
                stage_load = 1'b1;
                load_data  = reload_reg;
              end else begin
                dec_en     = 1'b1;
                state_next = ST_EXPIRED;
              end
            end else begin
              // Guard keeps Q from ever wrapping below zero.
              dec_en = ~q_zero;
            end
          end
        end
        ST_EXPIRED: state_next = ST_EXPIRED;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_sync_down_timer.sv
module tb_four_bit_sync_down_timer;

  typedef struct {
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       ar;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       expd;
    logic       tc;
  } vec_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       count_enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic [3:0] Q;
  logic       busy;
  logic       done;
  logic       expired;
  logic       tc;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  four_bit_sync_down_timer #(.WIDTH(4)) dut (
    .clk          (clk),
    .clear        (clear),
    .count_enable (count_enable),
    .load         (load),
    .load_value   (load_value),
    .auto_reload  (auto_reload),
    .Q            (Q),
    .busy         (busy),
    .done         (done),
    .expired      (expired),
    .tc           (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input int lv, input logic en, input logic ar,
                              input int q, input logic b, input logic d, input logic e,
                              input logic t);
    vec_t v;
    v.load = ld; v.lv = 4'(lv); v.en = en; v.ar = ar;
    v.q = 4'(q); v.busy = b; v.done = d; v.expd = e; v.tc = t;
    return v;
  endfunction

  // Drive one cycle: tc checked before the edge, registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    load = v.load; load_value = v.lv; count_enable = v.en; auto_reload = v.ar;
    #1;
    chk({tag, ".tc"}, 32'(tc), 32'(v.tc));
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".q"},       32'(Q),       32'(e.q));
      chk({tag, ".busy"},    32'(busy),    32'(e.busy));
      chk({tag, ".done"},    32'(done),    32'(e.done));
      chk({tag, ".expired"}, 32'(expired), 32'(e.expd));
    end
  endtask

  initial begin
    clear = 1'b0; count_enable = 1'b0; load = 1'b0; load_value = '0; auto_reload = 1'b0;

    // T2 one-shot
    tbl.push_back(mk(1, 3, 1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    // T3 periodic, then auto_reload dropped mid-run
    tbl.push_back(mk(1, 4, 1, 1, 4, 1, 0, 0, 0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0, 0, 1, 1, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 4, 1, 1, 0, 1));
    end
    tbl.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    // T4 gating, loaded from EXPIRED
    tbl.push_back(mk(1, 2, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    // T5 load collides with terminal count, then load of zero
    tbl.push_back(mk(1, 2, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 0, 5, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));

    // Reset values without any clock edge
    #1;
    chk("reset.q", 32'(Q), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.expired", 32'(expired), 32'd0);
    @(negedge clk);
    clear = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));

    // T6 full-scale load counts 15..1 then stays at 0
    apply(mk(1, 15, 1, 0, 15, 1, 0, 0, 0), "w.load");
    for (int k = 14; k >= 1; k--)
      apply(mk(0, 0, 1, 0, k, 1, 0, 0, 0), $sformatf("w.dec%0d", k));
    apply(mk(0, 0, 1, 0, 0, 0, 1, 1, 1), "w.tc");
    for (int k = 0; k < 3; k++)
      apply(mk(0, 0, 1, 0, 0, 0, 0, 1, 0), $sformatf("w.hold%0d", k));

    // T1 async clear mid-count at Q=5
    apply(mk(1, 7, 1, 0, 7, 1, 0, 0, 0), "t1.load");
    apply(mk(0, 0, 1, 0, 6, 1, 0, 0, 0), "t1.dec6");
    apply(mk(0, 0, 1, 0, 5, 1, 0, 0, 0), "t1.dec5");
    @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    chk("t1.q", 32'(Q), 32'd0);
    chk("t1.busy", 32'(busy), 32'd0);
    chk("t1.done", 32'(done), 32'd0);
    chk("t1.expired", 32'(expired), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 0), "t1.idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
